fifo_reader_8x16: RTL and testbench

FIFO_READER_8X16 -- requirements
Module: fifo_reader_8x16

---
 rtl/fifo_reader_8x16.sv | 128 ++++++++++++
 tb/tb_fifo_reader_8x16.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader_8x16.sv
// fifo_reader_8x16: paced, single-outstanding pop engine for an 8-bit FIFO read port.
// Optional macro FIFO_RD_POP_COUNT_EN adds o_Pop_Count, an 8-bit wrapping capture counter.

module fifo_reader_8x16 #(
  parameter int unsigned PACE_CLKS  = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Enable,
  input  logic       i_FIFO_Empty,
  input  logic [7:0] i_Data_Read,
  input  logic       i_Ready,
  output logic       o_Switch_Rd_Wr,
  output logic       o_Btn_Next,
  output logic       o_Busy,
  output logic [7:0] o_Data,
  output logic       o_Valid
`ifdef FIFO_RD_POP_COUNT_EN
  ,
  output logic [7:0] o_Pop_Count
`endif
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PACE_W = 8;
  localparam int unsigned WAIT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PACE_W-1:0]   pace_q,  pace_d;
  logic [WAIT_W-1:0]   wait_q,  wait_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                valid_q, valid_d;
  logic                btn_q,   btn_d;
  logic                busy_q,  busy_d;

  // State and registered outputs
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
      pace_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      btn_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pace_q  <= pace_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pace_d  = (pace_q != '0) ? pace_q - PACE_W'(1) : '0;
    wait_d  = wait_q;
    data_d  = data_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Enable && !i_FIFO_Empty && (pace_q == '0)) begin
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        state_d = ST_WAIT;
        wait_d  = WAIT_W'(RD_LATENCY - 1);
      end
      ST_WAIT: begin
        // Empty flag is not consulted here: the issued pop is always captured
        if (wait_q == '0) begin
          data_d  = i_Data_Read;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      ST_HOLD: begin
        if (valid_q && i_Ready) begin
          valid_d = 1'b0;
          pace_d  = PACE_W'(PACE_CLKS - 1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    btn_d  = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE);
  end

  assign o_Switch_Rd_Wr = 1'b0;
  assign o_Btn_Next     = btn_q;
  assign o_Busy         = busy_q;
  assign o_Data         = data_q;
  assign o_Valid        = valid_q;

`ifdef FIFO_RD_POP_COUNT_EN
  logic [7:0] pop_cnt_q;

  // Counts captures; wraps naturally at 8 bits
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      pop_cnt_q <= '0;
    end else if ((state_q == ST_WAIT) && (wait_q == '0)) begin
      pop_cnt_q <= pop_cnt_q + 8'd1;
    end
  end

  assign o_Pop_Count = pop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader_8x16.sv
// Scoreboard bench for fifo_reader_8x16: queue-based FIFO model, cycle-level
// pop-eligibility model and an in-order data scoreboard checked by a negedge monitor.

module tb_fifo_reader_8x16;

  localparam int unsigned PACE_CLKS  = 4;
  localparam int unsigned RD_LATENCY = 1;

  logic       i_Clk;
  logic       i_Reset_n;
  logic       i_Enable;
  logic       i_FIFO_Empty;
  logic [7:0] i_Data_Read;
  logic       i_Ready;
  logic       o_Switch_Rd_Wr;
  logic       o_Btn_Next;
  logic       o_Busy;
  logic [7:0] o_Data;
  logic       o_Valid;
`ifdef FIFO_RD_POP_COUNT_EN
  logic [7:0] o_Pop_Count;
`endif

  fifo_reader_8x16 #(
    .PACE_CLKS  (PACE_CLKS),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset_n      (i_Reset_n),
    .i_Enable       (i_Enable),
    .i_FIFO_Empty   (i_FIFO_Empty),
    .i_Data_Read    (i_Data_Read),
    .i_Ready        (i_Ready),
    .o_Switch_Rd_Wr (o_Switch_Rd_Wr),
    .o_Btn_Next     (o_Btn_Next),
    .o_Busy         (o_Busy),
    .o_Data         (o_Data),
    .o_Valid        (o_Valid)
`ifdef FIFO_RD_POP_COUNT_EN
    ,
    .o_Pop_Count    (o_Pop_Count)
`endif
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // External FIFO contents and expected delivery order
  logic [7:0] fifo_q[$];
  logic [7:0] sb_q[$];

  // Monitor/model state
  int         cyc       = 0;
  int         last_hs   = -1000;
  int         pulse_cyc = 0;
  int         rd_delay  = 0;
  int         pop_model = 0;
  bit         inflight  = 1'b0;
  bit         elig_prev = 1'b0;
  bit         valid_prev = 1'b0;
  bit         hs_prev   = 1'b0;
  logic [7:0] data_prev = '0;
  logic [7:0] rd_pending = '0;

  always @(negedge i_Clk) begin
    bit busy_now;
    bit hs;
    cyc++;
    if (!i_Reset_n) begin
      if (inflight && sb_q.size() > 0) void'(sb_q.pop_front());
      inflight   = 1'b0;
      last_hs    = -1000;
      elig_prev  = 1'b0;
      valid_prev = 1'b0;
      hs_prev    = 1'b0;
      rd_delay   = 0;
      pop_model  = 0;
      i_FIFO_Empty = (fifo_q.size() == 0);
    end else begin
      // A pop must occur exactly when the previous cycle allowed it
      chk("btn_next", int'(o_Btn_Next), int'(elig_prev));
      chk("switch_rd_wr", int'(o_Switch_Rd_Wr), 0);
      if (o_Btn_Next) begin
        inflight  = 1'b1;
        pulse_cyc = cyc;
        if (fifo_q.size() > 0) rd_pending = fifo_q.pop_front();
        rd_delay = int'(RD_LATENCY) - 1;
        i_Data_Read = (rd_delay == 0) ? rd_pending : 8'($urandom);
      end else if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) i_Data_Read = rd_pending;
      end
      chk("busy", int'(o_Busy), int'(inflight));
      if (o_Valid && !valid_prev) begin
        chk("valid_latency", cyc - pulse_cyc, int'(RD_LATENCY) + 1);
        pop_model = (pop_model + 1) % 256;
      end
      if (valid_prev && !hs_prev) begin
        chk("hold_valid", int'(o_Valid), 1);
        chk("hold_data", int'(o_Data), int'(data_prev));
      end
      if (hs_prev) chk("valid_drop", int'(o_Valid), 0);
      hs = o_Valid && i_Ready;
      if (hs) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("data", int'(o_Data), int'(sb_q.pop_front()));
        last_hs = cyc;
      end
`ifdef FIFO_RD_POP_COUNT_EN
      chk("pop_count", int'(o_Pop_Count), pop_model);
`endif
      busy_now = inflight;
      if (hs) inflight = 1'b0;
      i_FIFO_Empty = (fifo_q.size() == 0);
      elig_prev  = !busy_now && (cyc >= last_hs + int'(PACE_CLKS)) && i_Enable && !i_FIFO_Empty;
      valid_prev = o_Valid;
      data_prev  = o_Data;
      hs_prev    = hs;
    end
  end

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  // Waits (bounded) for the next negedge with o_Btn_Next high
  task automatic wait_btn(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge i_Clk);
      if (o_Btn_Next) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wait_btn_timeout", 0, 1);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    i_Enable = 1'b1;
    i_Ready  = 1'b1;
    while (sb_q.size() > 0 && n < bound) begin
      step(1);
      n++;
    end
    chk("drain_left", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    i_Reset_n    = 1'b0;
    i_Enable     = 1'b0;
    i_FIFO_Empty = 1'b1;
    i_Data_Read  = 8'h00;
    i_Ready      = 1'b0;
    step(3);
    chk("rst_valid", int'(o_Valid), 0);
    chk("rst_data", int'(o_Data), 0);
    chk("rst_busy", int'(o_Busy), 0);
    chk("rst_btn", int'(o_Btn_Next), 0);
    i_Reset_n = 1'b1;
    step(2);

    // Single pop with explicit timing
    i_Enable = 1'b1;
    i_Ready  = 1'b1;
    push(8'h22);
    wait_btn(20, ok);
    if (ok) begin
      chk("single_busy_t", int'(o_Busy), 1);
      @(negedge i_Clk);
      chk("single_btn_t1", int'(o_Btn_Next), 0);
      chk("single_busy_t1", int'(o_Busy), 1);
      @(negedge i_Clk);
      chk("single_valid_t2", int'(o_Valid), 1);
      chk("single_data_t2", int'(o_Data), 8'h22);
      chk("single_busy_t2", int'(o_Busy), 1);
    end
    step(10);

    // Back-to-back: second pop PACE_CLKS idle cycles after the handshake
    push(8'h22);
    push(8'hDD);
    wait_btn(20, ok);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_Clk);
      if (o_Valid && i_Ready) break;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge i_Clk);
      n++;
      if (o_Btn_Next) break;
    end
    chk("pace_gap", n, int'(PACE_CLKS) + 1);
    @(negedge i_Clk);
    @(negedge i_Clk);
    chk("b2b_data", int'(o_Data), 8'hDD);
    step(10);

    // Backpressure for 10 cycles
    i_Ready = 1'b0;
    push(8'h22);
    wait_btn(20, ok);
    step(RD_LATENCY + 1);
    step(10);
    chk("bp_data", int'(o_Data), 8'h22);
    chk("bp_valid", int'(o_Valid), 1);
    i_Ready = 1'b1;
    step(1);
    chk("bp_drop", int'(o_Valid), 0);
    step(10);

    // Empty FIFO, then disabled with data present
    step(50);
    i_Enable = 1'b0;
    push(8'h5A);
    step(50);
    chk("disabled_pending", fifo_q.size(), 1);
    i_Enable = 1'b1;
    wait_btn(20, ok);
    step(0);
    @(posedge i_Clk);
    #1 i_Enable = 1'b0;
    step(20);
    chk("en_drop_delivered", sb_q.size(), 0);
    i_Enable = 1'b1;

    // Async reset mid-HOLD discards the held word
    i_Ready = 1'b0;
    push(8'h22);
    wait_btn(20, ok);
    step(RD_LATENCY + 2);
    chk("pre_rst_data", int'(o_Data), 8'h22);
    @(negedge i_Clk);
    #1 i_Reset_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(o_Valid), 0);
    chk("async_rst_data", int'(o_Data), 0);
    chk("async_rst_busy", int'(o_Busy), 0);
    step(2);
    i_Reset_n = 1'b1;
    i_Ready = 1'b1;
    step(5);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      i_Enable = ($urandom_range(0, 3) != 0);
      i_Ready  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0 && fifo_q.size() < 16) push(8'($urandom));
      step(1);
    end
    drain(1000);

`ifdef FIFO_RD_POP_COUNT_EN
    i_Reset_n = 1'b0;
    step(2);
    i_Reset_n = 1'b1;
    for (int i = 0; i < 257; i++) push(8'($urandom));
    drain(257 * 12 + 100);
    step(2);
    chk("pop_count_257", int'(o_Pop_Count), 8'h01);
`endif

    step(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
